// File: rtl/stc0_byte_egress_fifo_if.sv
// Egress word/byte bus for stc0_byte_egress_fifo: word push side, byte stream side
// with backpressure, and FIFO status.
interface stc0_byte_egress_fifo_if #(
  parameter int WORD_WIDTH      = 32,
  parameter int FIFO_DEPTH_LOG2 = 2
);
  logic [WORD_WIDTH-1:0]    write_data;
  logic                     write_data_valid;
  logic                     msb_first;
  logic                     ready;
  logic [7:0]               data;
  logic                     data_valid;
  logic                     data_ready;
  logic [FIFO_DEPTH_LOG2:0] level;
  logic                     overflow;
  logic                     clear_overflow;

  modport master (
    output write_data, write_data_valid, msb_first, data_ready, clear_overflow,
    input  ready, data, data_valid, level, overflow
  );

  modport slave (
    input  write_data, write_data_valid, msb_first, data_ready, clear_overflow,
    output ready, data, data_valid, level, overflow
  );
endinterface

// File: rtl/stc0_byte_egress_fifo.sv
// Word FIFO feeding a byte serializer onto the egress bus; byte order chosen per word,
// downstream backpressure honoured, dropped writes flagged in a sticky overflow bit.
module stc0_byte_egress_fifo #(
  parameter int WORD_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input logic                    clk,
  input logic                    rst,
  stc0_byte_egress_fifo_if.slave bus
);
  localparam int N_BYTES = WORD_WIDTH / 8;
  localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int LVL_W   = FIFO_DEPTH_LOG2 + 1;

  localparam logic [LVL_W-1:0]           LEVEL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]           LEVEL_EMPTY = LVL_W'(0);
  localparam logic [LVL_W-1:0]           LEVEL_ONE   = LVL_W'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ZERO    = FIFO_DEPTH_LOG2'(0);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE     = FIFO_DEPTH_LOG2'(1);
  localparam logic [IDX_W-1:0]           IDX_ZERO    = IDX_W'(0);
  localparam logic [IDX_W-1:0]           IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0]           IDX_LAST    = IDX_W'(N_BYTES - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Each entry is {msb_first, word} so the byte order travels with its word.
  logic [WORD_WIDTH:0]          mem_r [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr_r;
  logic [FIFO_DEPTH_LOG2-1:0]   rd_ptr_r;
  logic [LVL_W-1:0]             level_r;
  logic [0:0]                   state_r;
  logic [WORD_WIDTH-1:0]        shift_word_r;
  logic                         shift_msb_r;
  logic [IDX_W-1:0]             byte_idx_r;
  logic [7:0]                   data_r;
  logic                         data_valid_r;
  logic                         overflow_r;

  logic                         ready_s;
  logic                         push_s;
  logic                         drop_s;
  logic                         pop_s;
  logic                         last_xfer_s;
  logic [WORD_WIDTH-1:0]        head_word_s;
  logic                         head_msb_s;

  function automatic logic [7:0] pick_byte(input logic [WORD_WIDTH-1:0] word,
                                           input logic                  msb,
                                           input logic [IDX_W-1:0]      idx);
    logic [WORD_WIDTH-1:0] shifted;
    if (msb) begin
      shifted = word >> ((N_BYTES - 1 - int'(idx)) * 8);
    end else begin
      shifted = word >> (int'(idx) * 8);
    end
    return shifted[7:0];
  endfunction

  // Handshake decode; Ready comes from the registered level only, so a full FIFO
  // drops a write even when a pop happens on the same edge.
  always_comb begin
    ready_s     = (level_r != LEVEL_FULL);
    push_s      = bus.write_data_valid & ready_s;
    drop_s      = bus.write_data_valid & ~ready_s;
    last_xfer_s = (state_r == ST_SHIFT) && bus.data_ready && (byte_idx_r == IDX_LAST);
    pop_s       = (level_r != LEVEL_EMPTY) && ((state_r == ST_IDLE) || last_xfer_s);
    {head_msb_s, head_word_s} = mem_r[rd_ptr_r];
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {bus.msb_first, bus.write_data};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LEVEL_EMPTY;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LEVEL_ONE;
        2'b01:   level_r <= level_r - LEVEL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (bus.clear_overflow) begin
      overflow_r <= 1'b0;
    end
  end

  // Serializer: loads the head word and walks its bytes, back-to-back across words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      shift_word_r <= {WORD_WIDTH{1'b0}};
      shift_msb_r  <= 1'b0;
      byte_idx_r   <= IDX_ZERO;
      data_r       <= 8'h00;
      data_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            shift_word_r <= head_word_s;
            shift_msb_r  <= head_msb_s;
            byte_idx_r   <= IDX_ZERO;
            data_r       <= pick_byte(head_word_s, head_msb_s, IDX_ZERO);
            data_valid_r <= 1'b1;
            state_r      <= ST_SHIFT;
          end else begin
            data_valid_r <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (last_xfer_s && pop_s) begin
            shift_word_r <= head_word_s;
            shift_msb_r  <= head_msb_s;
            byte_idx_r   <= IDX_ZERO;
            data_r       <= pick_byte(head_word_s, head_msb_s, IDX_ZERO);
            data_valid_r <= 1'b1;
          end else if (last_xfer_s) begin
            byte_idx_r   <= IDX_ZERO;
            data_valid_r <= 1'b0;
            state_r      <= ST_IDLE;
          end else if (bus.data_ready) begin
            byte_idx_r   <= byte_idx_r + IDX_ONE;
            data_r       <= pick_byte(shift_word_r, shift_msb_r, byte_idx_r + IDX_ONE);
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          data_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready      = ready_s;
  assign bus.data       = data_r;
  assign bus.data_valid = data_valid_r;
  assign bus.level      = level_r;
  assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_stc0_byte_egress_fifo.sv
// Directed bench: a 32-bit/depth-4 instance for ordering, overflow, backpressure and
// reset, and an 8-bit/depth-2 instance for the single-byte-word corners.
module tb_stc0_byte_egress_fifo;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  stc0_byte_egress_fifo_if #(.WORD_WIDTH(32), .FIFO_DEPTH_LOG2(2)) a_if ();
  stc0_byte_egress_fifo_if #(.WORD_WIDTH(8),  .FIFO_DEPTH_LOG2(1)) b_if ();

  stc0_byte_egress_fifo #(.WORD_WIDTH(32), .FIFO_DEPTH(4), .FIFO_DEPTH_LOG2(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  stc0_byte_egress_fifo #(.WORD_WIDTH(8), .FIFO_DEPTH(2), .FIFO_DEPTH_LOG2(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] t;
    logic [7:0]  exp_ready;
    logic [31:0] acc[$];
    logic [7:0]  rx[$];
    logic [7:0]  bp_exp[12];
    logic        stall_prev;
    logic [7:0]  prev_data;
    logic        dr;
    int          b;

    rst = 1'b1;
    a_if.write_data = 32'h0; a_if.write_data_valid = 1'b0; a_if.msb_first = 1'b0;
    a_if.data_ready = 1'b0;  a_if.clear_overflow = 1'b0;
    b_if.write_data = 8'h0;  b_if.write_data_valid = 1'b0; b_if.msb_first = 1'b0;
    b_if.data_ready = 1'b0;  b_if.clear_overflow = 1'b0;
    step();
    step();
    chk("rst_a_dv",    32'(a_if.data_valid), 32'd0);
    chk("rst_a_data",  32'(a_if.data),       32'h00);
    chk("rst_a_level", 32'(a_if.level),      32'd0);
    chk("rst_a_ready", 32'(a_if.ready),      32'd1);
    chk("rst_a_ovf",   32'(a_if.overflow),   32'd0);
    chk("rst_b_dv",    32'(b_if.data_valid), 32'd0);
    chk("rst_b_ready", 32'(b_if.ready),      32'd1);
    rst = 1'b0;
    step();

    // MSB-first word: byte 0 valid one edge after the write edge.
    w = 32'hA1B2C3D4;
    a_if.write_data = w; a_if.msb_first = 1'b1; a_if.write_data_valid = 1'b1;
    a_if.data_ready = 1'b1;
    step();
    a_if.write_data_valid = 1'b0;
    chk("msb_level_after_push", 32'(a_if.level),      32'd1);
    chk("msb_dv_before_pop",    32'(a_if.data_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("msb_dv",   32'(a_if.data_valid), 32'd1);
      chk("msb_byte", 32'(a_if.data),       32'(w[31-8*k -: 8]));
    end
    step();
    chk("msb_dv_fall", 32'(a_if.data_valid), 32'd0);

    // LSB-first word.
    a_if.write_data = w; a_if.msb_first = 1'b0; a_if.write_data_valid = 1'b1;
    step();
    a_if.write_data_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("lsb_dv",   32'(a_if.data_valid), 32'd1);
      chk("lsb_byte", 32'(a_if.data),       32'(w[8*k+7 -: 8]));
    end
    step();
    chk("lsb_dv_fall", 32'(a_if.data_valid), 32'd0);

    // Eight back-to-back writes: words 5 and 7 meet a full FIFO and are dropped.
    exp_ready = 8'b0101_1111;
    a_if.msb_first = 1'b1;
    for (int c = 0; c < 28; c++) begin
      if (c < 8) begin
        w = {8'hA0 + 8'(c), 8'hB0 + 8'(c), 8'hC0 + 8'(c), 8'hD0 + 8'(c)};
        chk("ovf_ready", 32'(a_if.ready), 32'(exp_ready[c]));
        a_if.write_data = w;
        a_if.write_data_valid = 1'b1;
        if (exp_ready[c]) acc.push_back(w);
      end else begin
        a_if.write_data_valid = 1'b0;
      end
      step();
      if (c == 4) chk("ovf_level_full", 32'(a_if.level), 32'd4);
      if (c == 4) chk("ovf_flag_before_drop", 32'(a_if.overflow), 32'd0);
      if (c == 5) chk("ovf_flag_set", 32'(a_if.overflow), 32'd1);
      if (c >= 1 && c <= 24) begin
        b = c - 1;
        t = acc[b/4];
        chk("drain_dv",   32'(a_if.data_valid), 32'd1);
        chk("drain_byte", 32'(a_if.data),       32'(t[31-8*(b%4) -: 8]));
      end else begin
        chk("drain_idle", 32'(a_if.data_valid), 32'd0);
      end
    end
    chk("ovf_still_set", 32'(a_if.overflow), 32'd1);
    a_if.clear_overflow = 1'b1;
    step();
    a_if.clear_overflow = 1'b0;
    chk("ovf_cleared", 32'(a_if.overflow), 32'd0);

    // Random backpressure over three queued words.
    bp_exp = '{8'h01, 8'h23, 8'h45, 8'h67, 8'hEF, 8'hCD, 8'hAB, 8'h89,
               8'h0F, 8'h1E, 8'h2D, 8'h3C};
    stall_prev = 1'b0;
    prev_data  = 8'h00;
    a_if.data_ready = 1'b0;
    for (int c = 0; c < 300 && rx.size() < 12; c++) begin
      a_if.write_data_valid = (c < 3);
      case (c)
        0:       begin a_if.write_data = 32'h01234567; a_if.msb_first = 1'b1; end
        1:       begin a_if.write_data = 32'h89ABCDEF; a_if.msb_first = 1'b0; end
        default: begin a_if.write_data = 32'h0F1E2D3C; a_if.msb_first = 1'b1; end
      endcase
      if (stall_prev) begin
        chk("bp_hold_dv",   32'(a_if.data_valid), 32'd1);
        chk("bp_hold_data", 32'(a_if.data),       32'(prev_data));
      end
      dr = 1'($urandom_range(0, 1));
      a_if.data_ready = dr;
      if (a_if.data_valid && dr) rx.push_back(a_if.data);
      stall_prev = a_if.data_valid && !dr;
      prev_data  = a_if.data;
      step();
    end
    a_if.write_data_valid = 1'b0;
    chk("bp_byte_count", 32'(rx.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < rx.size()) chk("bp_byte", 32'(rx[i]), 32'(bp_exp[i]));
    end
    chk("bp_idle_after", 32'(a_if.data_valid), 32'd0);

    // Reset in the middle of a word, with a second word queued.
    a_if.data_ready = 1'b1;
    a_if.msb_first = 1'b1;
    a_if.write_data = 32'h11223344; a_if.write_data_valid = 1'b1;
    step();
    a_if.write_data = 32'h99AABBCC;
    step();
    a_if.write_data_valid = 1'b0;
    chk("mid_byte0", 32'(a_if.data), 32'h11);
    step();
    chk("mid_byte1",  32'(a_if.data),  32'h22);
    chk("mid_level1", 32'(a_if.level), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_dv",    32'(a_if.data_valid), 32'd0);
    chk("mid_rst_level", 32'(a_if.level),      32'd0);
    chk("mid_rst_data",  32'(a_if.data),       32'h00);
    step();
    rst = 1'b0;
    step();
    chk("mid_no_resume", 32'(a_if.data_valid), 32'd0);
    w = 32'h55667788;
    a_if.write_data = w; a_if.write_data_valid = 1'b1;
    step();
    a_if.write_data_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_byte", 32'(a_if.data), 32'(w[31-8*k -: 8]));
    end
    step();
    chk("post_rst_dv_fall", 32'(a_if.data_valid), 32'd0);
    step();
    chk("post_rst_quiet", 32'(a_if.data_valid), 32'd0);
    chk("post_rst_level", 32'(a_if.level),      32'd0);

    // Single-byte words: push and pop on the same edge at level 1.
    b_if.data_ready = 1'b0;
    b_if.write_data = 8'h5A; b_if.write_data_valid = 1'b1;
    step();
    chk("n1_level_a", 32'(b_if.level), 32'd1);
    b_if.write_data = 8'h6B;
    step();
    chk("n1_level_b", 32'(b_if.level), 32'd1);
    chk("n1_data_a",  32'(b_if.data),  32'h5A);
    b_if.write_data = 8'h7C; b_if.data_ready = 1'b1;
    step();
    b_if.write_data_valid = 1'b0;
    chk("n1_pushpop_level", 32'(b_if.level), 32'd1);
    chk("n1_data_b",        32'(b_if.data),  32'h6B);
    step();
    chk("n1_data_c",  32'(b_if.data),  32'h7C);
    chk("n1_level_0", 32'(b_if.level), 32'd0);
    step();
    chk("n1_idle", 32'(b_if.data_valid), 32'd0);

    // Fill the depth-2 FIFO, then a dropped write against ClearOverflow.
    b_if.data_ready = 1'b0;
    b_if.write_data_valid = 1'b1;
    b_if.write_data = 8'h11; step();
    b_if.write_data = 8'h22; step();
    b_if.write_data = 8'h33; step();
    chk("full_ready", 32'(b_if.ready), 32'd0);
    chk("full_level", 32'(b_if.level), 32'd2);
    b_if.write_data = 8'h44; b_if.clear_overflow = 1'b1;
    step();
    b_if.write_data_valid = 1'b0; b_if.clear_overflow = 1'b0;
    chk("set_beats_clear", 32'(b_if.overflow), 32'd1);
    chk("full_head",       32'(b_if.data),     32'h11);
    b_if.clear_overflow = 1'b1;
    step();
    b_if.clear_overflow = 1'b0;
    chk("b_ovf_cleared", 32'(b_if.overflow), 32'd0);
    b_if.data_ready = 1'b1;
    step();
    chk("full_drain_q", 32'(b_if.data), 32'h22);
    step();
    chk("full_drain_r", 32'(b_if.data), 32'h33);
    step();
    chk("full_drain_idle",  32'(b_if.data_valid), 32'd0);
    chk("full_drain_level", 32'(b_if.level),      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stc0_byte_egress_fifo.md
# stc0_byte_egress_fifo

Parametrised successor to the stc0 byte egress path. It accepts result words of configurable width from the egress stage into a word FIFO of configurable depth, and serialises each word onto the 8-bit egress bus. Byte order is selectable per word. The byte bus carries downstream backpressure. Overflow is reported through a sticky flag.

## Interface
- WORD_WIDTH, 32, egress word width; must be a multiple of 8, minimum 8; N = WORD_WIDTH/8 bytes per word
- FIFO_DEPTH, 4, word FIFO entries; must be a power of 2, minimum 2
- FIFO_DEPTH_LOG2, 2, log2(FIFO_DEPTH)

- Clk  in  1  single clock for the whole block; all state changes on the rising edge
- ARst  in  1  reset, asynchronous and active-high
- WriteData  in  WORD_WIDTH  word from the egress stage
- WriteDataValid  in  1  WriteData is valid this cycle
- MsbFirst  in  1  byte order for the word being written: 1 = most-significant byte first; stored alongside the word
- Ready  out  1  FIFO can accept a word; equals (Level != FIFO_DEPTH)
- Data  out  8  egress byte
- DataValid  out  1  Data is valid
- DataReady  in  1  downstream accepts Data this cycle
- Level  out  FIFO_DEPTH_LOG2+1  words held in the FIFO; excludes the word in the shift register
- Overflow  out  1  sticky flag: a word was dropped
- ClearOverflow  in  1  synchronous clear of Overflow

## Operation
- Write: when WriteDataValid=1 and Ready=1, the pair {MsbFirst, WriteData} is pushed.
- Dropped write: when WriteDataValid=1 and Ready=0, the word is discarded and Overflow is set.
  - Ready is derived from the registered Level only.
  - A write while full is dropped even if a pop happens in the same cycle.
- Overflow priority: a set in the same cycle as ClearOverflow wins.
- Serializer FSM has two states, IDLE and SHIFT.
- IDLE: DataValid=0.
  - If Level>0, pop the head word into the shift register, go to SHIFT, and present byte 0.
- SHIFT: DataValid=1.
  - A byte is transferred when DataValid=1 and DataReady=1; the byte index then increments.
  - While DataReady=0, Data and DataValid hold stable.
- Byte order:
  - Byte k (k=0..N-1) is WriteData[WORD_WIDTH-1-8k -: 8] when the stored MsbFirst=1.
  - Otherwise byte k is WriteData[8k+7 -: 8].
- End of word: when byte N-1 transfers, pop the next word in the same cycle if Level>0 and stay in SHIFT. Otherwise go to IDLE.
- Simultaneous push and pop: Level is unchanged; FIFO storage and pointers stay correct.
- Pointers wrap modulo FIFO_DEPTH.
- N=1: every word is a single byte; the end-of-word rule applies on every transfer.
- Reset (asynchronous, including mid-word):
  - FIFO pointers, Level, byte index, FSM and Overflow are cleared.
  - Any word in flight is discarded; no partial word resumes after release.
- Reset values: Data=8'h00, DataValid=0, Level=0, Ready=1, Overflow=0, FSM=IDLE.

## Timing
- Latency: a word written at edge E into an empty FIFO with the FSM in IDLE:
  - is popped at edge E+1;
  - byte 0 is valid after E+1;
  - with DataReady held high, byte N-1 is valid after E+N.
- Throughput: 1 byte per cycle while DataReady=1, with no bubble between consecutive words when the FIFO is non-empty.
- Registered outputs: Data, DataValid, Level and Overflow.
- Combinational output: Ready, decoded from the registered Level.
- Level updates one edge after a push or pop.

## Test plan
- Byte order MSB: WORD_WIDTH=32, write 32'hA1B2C3D4 with MsbFirst=1, DataReady=1 → A1, B2, C3, D4 on 4 consecutive cycles; the first is valid one cycle after the write edge; DataValid then falls.
- Byte order LSB: same word with MsbFirst=0 → D4, C3, B2, A1.
- Overflow and no-bubble drain: FIFO_DEPTH=4; write 8 words on consecutive cycles with DataReady=1.
  - Ready falls once Level reaches 4.
  - Words presented while Ready=0 are dropped and Overflow=1.
  - Accepted words stream out contiguously with no idle cycle between words.
  - Pulsing ClearOverflow then returns Overflow to 0.
- Backpressure: toggle DataReady randomly during 3 queued words → Data stays stable whenever DataValid=1 and DataReady=0; the byte sequence is complete and in order.
- Mid-word reset: assert ARst after byte 1 of 32'h11223344 → DataValid=0 and Level=0 immediately. After release, writing 32'h55667788 (MsbFirst=1) yields 55, 66, 77, 88 only.
- Corner cases:
  - WORD_WIDTH=8, FIFO_DEPTH=2: push and pop in the same cycle at Level=1 keeps Level=1.
  - WriteDataValid together with ClearOverflow while full leaves Overflow=1.
